fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage with IF/ID pipeline register. Owns the PC, drives the instruction-memory request handshake, and presents the fetched instruction, its PC and its opcode field to the decode stage. The main decoder consumes `if_id_instr[6:0]` directly. Branch redirects come from EX; stalls come from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `XLEN`, default 32: width of PC and instruction.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  XLEN  fetch address; equals `pc`.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  XLEN  instruction word, valid when `imem_req & imem_ready`.
- `stall`  in  1  hold IF/ID contents; do not deliver a new instruction.
- `branch_taken`  in  1  redirect request from EX, single-cycle pulse.
- `branch_target`  in  XLEN  redirect address, valid with `branch_taken`.
- `pc`  out  XLEN  current fetch PC.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_instr`  out  XLEN  instruction to decode.
- `if_id_pc`  out  XLEN  PC of `if_id_instr`.
- `opcode`  out  7  `if_id_instr[6:0]`.

## Operation
- Priority: `reset` > `branch_taken` > `stall`.
- Reset values:
  - `pc`=RESET_PC, state FETCH.
  - `if_id_valid`=0, `if_id_instr`=NOP (32'h0000_0013), `if_id_pc`=0.
  - `imem_req`=0 while `reset`=1.
- Invariant: whenever `if_id_valid`=0, `if_id_instr`=NOP. The decoder then sees an I-type opcode writing x0, with no MemWrite and no Branch.
- Handshake:
  - `imem_addr` must stay stable while `imem_req`=1 and `imem_ready`=0.
  - A transfer completes on an edge where `imem_req & imem_ready`.
- States:
  - FETCH: `imem_req`=1.
    - On transfer with no stall and no branch: IF/ID ← {1, rdata, pc}; `pc` ← `pc`+4.
    - On transfer with stall: rdata goes to the skid buffer, `pc` ← `pc`+4, go to HOLD.
    - Branch with transfer in the same cycle: discard rdata, `pc` ← target, stay in FETCH.
    - Branch without transfer: latch target into the redirect register, go to DRAIN.
  - DRAIN: `imem_req`=1 at the old address.
    - On transfer: discard rdata, `pc` ← redirect register, go to FETCH.
    - A new branch in DRAIN overwrites the redirect register.
  - HOLD: `imem_req`=0.
    - When stall drops: IF/ID ← skid buffer, go to FETCH.
    - Branch in HOLD: discard skid contents, `pc` ← target, go to FETCH.
- Flush: `branch_taken` clears IF/ID to invalid/NOP on the next edge, even if `stall`=1.
- Stall without branch: IF/ID is unchanged.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are not checked.
- `reset` asserted in any state wins immediately on the next edge, and drops any outstanding request, skid contents or redirect.

## Timing
- Zero-wait memory (`imem_ready` tied high): one instruction per cycle. The instruction fetched at edge N appears in IF/ID after edge N.
- Branch penalty: target fetch starts the cycle after `branch_taken`. In DRAIN, it starts the cycle after the old transfer completes.
- `opcode`, `if_id_*` and `pc` are registered outputs. `imem_req` and `imem_addr` are decoded from state and `pc` only, with no combinational path from `stall` or `branch_taken`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `cnt_fetch` (32) and `cnt_flush` (32).
  - `cnt_fetch` increments on each instruction written valid into IF/ID.
  - `cnt_flush` increments on each `branch_taken` edge that is not masked by reset.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the counter ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Shared `riscv_pkg`: `NOP_INSTR` constant, opcode constants (R_TYPE, I_TYPE, LW, SW, BR), and the `fetch_state_t` enum {FETCH, DRAIN, HOLD}.
- One sub-module, `fetch_skid_buf`: a one-entry {instr, pc} buffer with load, unload and clear.

## Test plan
- Reset, then `imem_ready`=1, memory word = 32'h0010_0093 at every address → `if_id_pc` sequence 0, 4, 8; `opcode`=7'b0010011; `if_id_valid`=1 from the second cycle after reset release.
- `stall` held 3 cycles while `imem_ready`=1 → IF/ID frozen; exactly one extra fetch enters HOLD; after release, PCs continue without skip or duplicate.
- `branch_taken` with target 32'h100 while a transfer completes → next `if_id_valid`=0 with NOP, then `if_id_pc`=32'h100.
- `imem_ready` low 2 cycles and branch to 32'h40 in the first → `imem_addr` stays at the old PC until ready, that data is dropped, then `imem_addr`=32'h40.
- `branch_taken` and `stall` in the same cycle during HOLD → skid discarded, IF/ID invalid, `pc`=target.
- `reset` asserted in DRAIN → next cycle `pc`=RESET_PC, `if_id_valid`=0, `imem_req`=0; counters=0 with `FETCH_PERF_CNT_EN`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: NOP, major opcodes, fetch states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BR     = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that catches a word fetched under stall.
module fetch_skid_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            instr <= XLEN'(NOP_INSTR);
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
            instr <= XLEN'(NOP_INSTR);
            pc    <= '0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, imem handshake and IF/ID register.
// Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     cnt_fetch,
    output logic [31:0]     cnt_flush,
`endif
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [6:0]      opcode
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] redir;
    logic            redir_ld;
    logic            ifid_ld, ifid_clr;
    logic            skid_ld, skid_unld, skid_clr;
    logic            skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc;

    // Request depends only on state (reset just masks it)
    assign imem_req  = ~reset & (state != HOLD);
    assign imem_addr = pc;
    assign opcode    = if_id_instr[6:0];

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        redir_ld  = 1'b0;
        ifid_ld   = 1'b0;
        ifid_clr  = 1'b0;
        skid_ld   = 1'b0;
        skid_unld = 1'b0;
        skid_clr  = 1'b0;
        unique case (state)
            FETCH: begin
                if (branch_taken) begin
                    ifid_clr = 1'b1;
                    if (imem_ready) begin
                        pc_d = branch_target;
                    end else begin
                        redir_ld = 1'b1;
                        state_d  = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc + XLEN'(4);
                    if (stall) begin
                        skid_ld = 1'b1;
                        state_d = HOLD;
                    end else begin
                        ifid_ld = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_clr = 1'b1;
                end
            end
            DRAIN: begin
                ifid_clr = 1'b1;
                if (imem_ready) begin
                    state_d = FETCH;
                    pc_d    = branch_taken ? branch_target : redir;
                end else if (branch_taken) begin
                    redir_ld = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    skid_clr = 1'b1;
                    ifid_clr = 1'b1;
                    pc_d     = branch_target;
                    state_d  = FETCH;
                end else if (!stall) begin
                    skid_unld = 1'b1;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= XLEN'(RESET_PC);
            redir <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (redir_ld) redir <= branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ifid_clr) begin
            if_id_valid <= 1'b0;
            if_id_instr <= XLEN'(NOP_INSTR);
            if_id_pc    <= '0;
        end else if (skid_unld) begin
            if_id_valid <= skid_valid;
            if_id_instr <= skid_instr;
            if_id_pc    <= skid_pc;
        end else if (ifid_ld) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
        end
    end

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_ld),
        .unload     (skid_unld),
        .clear      (skid_clr),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_fetch <= '0;
            cnt_flush <= '0;
        end else begin
            if (ifid_ld || (skid_unld && skid_valid))
                cnt_fetch <= cnt_fetch + 32'd1;
            if (branch_taken)
                cnt_flush <= cnt_flush + 32'd1;
        end
    end
`endif

endmodule
